uart_frame_tx: RTL and testbench



---
 rtl/uart_frame_tx.sv | 197 +++++++++++++++++++
 tb/tb_uart_frame_tx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: latches an N_BYTES word on a data_rdy request and
// sends it as one 8N1 frame: optional header, payload MSB byte first, optional
// mod-256 checksum. Contains its own baud divider and serialiser.
module uart_frame_tx #(
  parameter int unsigned CLK_HZ    = 20000000,
  parameter int unsigned BAUD      = 500000,
  parameter int unsigned N_BYTES   = 3,
  parameter int unsigned HEADER_EN = 1,
  parameter logic [7:0]  HEADER    = 8'd123,
  parameter int unsigned CSUM_EN   = 0
) (
  input  logic                   clk_20m,
  input  logic                   rst_n,
  input  logic [8*N_BYTES-1:0]   data,
  input  logic                   data_rdy,
  output logic                   tx,
  output logic                   transm_rdy,
  output logic                   frame_done,
  output logic                   overrun
);

  // Clock cycles per bit; integer truncation, no fractional correction.
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned NB     = N_BYTES + HEADER_EN + CSUM_EN;
  localparam int unsigned CntW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned FrameW = 8 * NB;

  localparam logic [CntW-1:0] BaudLoad = CntW'(DIV - 1);
  // Byte index is 5 bits wide so it covers up to 17 bytes without wrapping.
  localparam logic [4:0]      LastByte = 5'(NB - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [4:0]          byte_q, byte_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic [7:0]          shift_q, shift_d;
  logic                armed_q, armed_d;
  logic                ovr_q, ovr_d;

  logic [7:0]          csum;
  logic [FrameW-1:0]   frame_word;
  logic [7:0]          cur_byte;
  logic                accept;
  logic                baud_tick;

  // Checksum over the payload bytes only; the header is excluded.
  always_comb begin
    csum = 8'h00;
    for (int unsigned i = 0; i < N_BYTES; i++) begin
      csum = csum + data[8*i +: 8];
    end
  end

  // Assemble the complete frame with the first byte to send in the top lane.
  always_comb begin
    frame_word = '0;
    frame_word[8*CSUM_EN +: 8*N_BYTES] = data;
    if (HEADER_EN != 0) begin
      frame_word[8*(NB-1) +: 8] = HEADER;
    end
    if (CSUM_EN != 0) begin
      frame_word[7:0] = csum;
    end
  end

  assign cur_byte   = frame_q[FrameW-1 -: 8];
  assign baud_tick  = (baud_q == '0);
  assign transm_rdy = (state_q == StIdle) || (state_q == StDone);
  assign accept     = data_rdy && armed_q && transm_rdy;

  // Request qualification: a request re-arms only after data_rdy is seen low.
  always_comb begin
    ovr_d   = data_rdy && armed_q && !transm_rdy;
    armed_d = armed_q;
    if (!data_rdy) begin
      armed_d = 1'b1;
    end else if (accept || ovr_d) begin
      armed_d = 1'b0;
    end
  end

  // Next-state logic for the frame sequencer and its counters.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    frame_d = frame_q;
    shift_d = shift_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = StStart;
          baud_d  = BaudLoad;
          bit_d   = 3'd0;
          byte_d  = 5'd0;
          frame_d = frame_word;
        end else begin
          state_d = StIdle;
        end
      end

      StStart: begin
        if (baud_tick) begin
          state_d = StData;
          baud_d  = BaudLoad;
          bit_d   = 3'd0;
          shift_d = cur_byte;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      StData: begin
        if (baud_tick) begin
          baud_d  = BaudLoad;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      StStop: begin
        if (baud_tick) begin
          if (byte_q < LastByte) begin
            // Next start bit follows the stop bit with no idle gap.
            state_d = StStart;
            baud_d  = BaudLoad;
            byte_d  = byte_q + 5'd1;
            frame_d = frame_q << 8;
          end else begin
            state_d = StDone;
            baud_d  = '0;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk_20m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 5'd0;
      frame_q <= '0;
      shift_q <= 8'h00;
      armed_q <= 1'b1;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      frame_q <= frame_d;
      shift_q <= shift_d;
      armed_q <= armed_d;
      ovr_q   <= ovr_d;
    end
  end

  // Line driver: start bit low, data LSB first, stop and idle high.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      StStart: tx = 1'b0;
      StData:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  assign frame_done = (state_q == StDone);
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: three configurations share one clock and reset;
// a serial receiver decodes the selected tx line and compares each byte
// against a queue filled when the request is driven.
`timescale 1ns/1ps
module tb_uart_frame_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] data_a = '0, data_c = '0;
  logic [7:0]  data_s = '0;
  logic        rdy_a = 1'b0, rdy_c = 1'b0, rdy_s = 1'b0;
  logic        tx_a, tx_c, tx_s;
  logic        trdy_a, trdy_c, trdy_s;
  logic        fd_a, fd_c, fd_s;
  logic        ovr_a, ovr_c, ovr_s;

  int          sel = 0;
  int          div_m;
  logic        tx_m, trdy_m, fd_m, ovr_m;

  logic [7:0]  exp_q[$];
  bit          mon_en = 1'b1;
  int          n_checks = 0;
  int          n_fail = 0;

  always #25 clk = ~clk;

  uart_frame_tx u_dut_a (
    .clk_20m(clk), .rst_n(rst_n), .data(data_a), .data_rdy(rdy_a),
    .tx(tx_a), .transm_rdy(trdy_a), .frame_done(fd_a), .overrun(ovr_a)
  );

  uart_frame_tx #(.CSUM_EN(1)) u_dut_c (
    .clk_20m(clk), .rst_n(rst_n), .data(data_c), .data_rdy(rdy_c),
    .tx(tx_c), .transm_rdy(trdy_c), .frame_done(fd_c), .overrun(ovr_c)
  );

  uart_frame_tx #(.N_BYTES(1), .HEADER_EN(0), .BAUD(5000000)) u_dut_s (
    .clk_20m(clk), .rst_n(rst_n), .data(data_s), .data_rdy(rdy_s),
    .tx(tx_s), .transm_rdy(trdy_s), .frame_done(fd_s), .overrun(ovr_s)
  );

  always_comb begin
    case (sel)
      0:       begin tx_m = tx_a; trdy_m = trdy_a; fd_m = fd_a; ovr_m = ovr_a; div_m = 40; end
      1:       begin tx_m = tx_c; trdy_m = trdy_c; fd_m = fd_c; ovr_m = ovr_c; div_m = 40; end
      default: begin tx_m = tx_s; trdy_m = trdy_s; fd_m = fd_s; ovr_m = ovr_s; div_m = 4;  end
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_rdy(input int s, input logic v);
    case (s)
      0:       rdy_a = v;
      1:       rdy_c = v;
      default: rdy_s = v;
    endcase
  endtask

  task automatic set_data(input int s, input logic [23:0] d);
    case (s)
      0:       data_a = d;
      1:       data_c = d;
      default: data_s = d[7:0];
    endcase
  endtask

  // Expected byte sequence for each configuration.
  task automatic push_frame(input int s, input logic [23:0] d);
    logic [7:0] cs;
    cs = d[23:16] + d[15:8] + d[7:0];
    if (s == 2) begin
      exp_q.push_back(d[7:0]);
    end else begin
      exp_q.push_back(8'h7B);
      exp_q.push_back(d[23:16]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back(d[7:0]);
      if (s == 1) exp_q.push_back(cs);
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain", 32'(exp_q.size()), 0);
  endtask

  // Sends one request and times the frame; optional overrun poke at ovr_at.
  task automatic run_frame(input int s, input logic [23:0] d, input int exp_len,
                           input int ovr_at);
    int cyc;
    int ovr_cnt;
    bit rdy_bad;
    push_frame(s, d);
    @(negedge clk);
    set_data(s, d);
    set_rdy(s, 1'b1);
    @(negedge clk);
    set_rdy(s, 1'b0);
    set_data(s, 24'($urandom));
    cyc = 1;
    ovr_cnt = 0;
    rdy_bad = 1'b0;
    check_eq("start_lat", tx_m, 0);
    while (!fd_m && cyc < exp_len + 50) begin
      if (trdy_m) rdy_bad = 1'b1;
      if (ovr_m) ovr_cnt++;
      if (ovr_at > 0 && cyc == ovr_at) begin
        set_data(s, 24'($urandom));
        set_rdy(s, 1'b1);
      end
      if (ovr_at > 0 && cyc == ovr_at + 1) set_rdy(s, 1'b0);
      @(negedge clk);
      cyc++;
    end
    check_eq("frame_len", cyc, exp_len);
    check_eq("rdy_in_frame", rdy_bad, 0);
    check_eq("rdy_at_done", trdy_m, 1);
    check_eq("ovr_count", ovr_cnt, (ovr_at > 0) ? 1 : 0);
    wait_drain();
  endtask

  // Line is high and idle for n cycles: no start bit, transmitter ready.
  task automatic check_quiet(input string tag, input int n);
    bit bad = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (!tx_m || !trdy_m || fd_m) bad = 1'b1;
    end
    check_eq(tag, bad, 0);
  endtask

  // Serial receiver on the selected line, sampling mid-bit.
  always begin : rx_mon
    logic [7:0] b;
    @(negedge clk);
    if (mon_en && rst_n && tx_m === 1'b0) begin
      repeat (div_m / 2) @(negedge clk);
      if (mon_en) check_eq("start_mid", tx_m, 0);
      for (int i = 0; i < 8; i++) begin
        repeat (div_m) @(negedge clk);
        b[i] = tx_m;
      end
      repeat (div_m) @(negedge clk);
      if (mon_en) begin
        check_eq("stop_bit", tx_m, 1);
        if (exp_q.size() == 0) check_eq("extra_byte", 32'(exp_q.size()), 1);
        else check_eq("rx_byte", b, exp_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin : stim
    int fd_cnt;
    int ovr_cnt;
    bit bad;

    repeat (3) @(negedge clk);
    check_eq("rst_tx", tx_a, 1);
    check_eq("rst_rdy", trdy_a, 1);
    check_eq("rst_done", fd_a, 0);
    check_eq("rst_ovr", ovr_a, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("idle_tx", tx_a, 1);

    // Default frame: 7B A1 B2 C3 at 40 cycles per bit.
    sel = 0;
    run_frame(0, 24'hA1B2C3, 1601, 0);

    // Checksum configuration: 7B FF 01 02 02.
    sel = 1;
    run_frame(1, 24'hFF0102, 2001, 0);

    // data_rdy held high yields exactly one frame and no overrun.
    sel = 0;
    push_frame(0, 24'h123456);
    @(negedge clk);
    data_a = 24'h123456;
    rdy_a  = 1'b1;
    fd_cnt = 0;
    ovr_cnt = 0;
    repeat (5000) begin
      @(negedge clk);
      if (fd_a) fd_cnt++;
      if (ovr_a) ovr_cnt++;
    end
    rdy_a = 1'b0;
    check_eq("held_frames", fd_cnt, 1);
    check_eq("held_ovr", ovr_cnt, 0);
    wait_drain();
    run_frame(0, 24'h0F1E2D, 1601, 0);

    // New request mid-frame: overrun pulse, frame untouched, nothing extra sent.
    run_frame(0, 24'h3C5AF0, 1601, 500);
    check_quiet("no_extra_frame", 2000);

    // Reset at cycle 900: line high at once, then a clean frame afterwards.
    push_frame(0, 24'hDEAD42);
    @(negedge clk);
    data_a = 24'hDEAD42;
    rdy_a  = 1'b1;
    @(negedge clk);
    rdy_a  = 1'b0;
    repeat (899) @(negedge clk);
    mon_en = 1'b0;
    #5;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_tx", tx_a, 1);
    check_eq("rst_mid_rdy", trdy_a, 1);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (!tx_a) bad = 1'b1;
    end
    check_eq("rst_hold_tx", bad, 0);
    rst_n = 1'b1;
    check_quiet("post_rst_quiet", 500);
    exp_q.delete();
    mon_en = 1'b1;
    run_frame(0, 24'h5AA55A, 1601, 0);

    // Single byte, no header, 4 cycles per bit.
    sel = 2;
    repeat (5) @(negedge clk);
    run_frame(2, 24'h000055, 41, 0);

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
